// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_pkg
//  Purpose  : Shared types for the external-SRAM port arbiter: FSM state
//             encoding, requester identifiers and the default address width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

    localparam int AW_DEFAULT = 21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REQ_VGA = 2'd0,
        REQ_CPU = 2'd1,
        REQ_DMA = 2'd2
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter_if
//  Purpose  : Bundles the three requester handshakes (VGA/CPU/DMA) and the
//             SRAM pad signals shared by the arbiter.
//  Modports : slave  - the arbiter (takes requests, drives acks and pads)
//             master - the requesters and pad model (drive requests, D_i)
//  Revision : 1.0  initial release
// ============================================================================
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT
);
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_ack;
    logic [7:0]    vga_rdata;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wdata;
    logic          dma_ack;
    logic [7:0]    dma_rdata;

    logic [AW-1:0] SRAM_A;
    logic [7:0]    SRAM_D_o;
    logic          SRAM_D_oe;
    logic [7:0]    SRAM_D_i;
    logic          SRAM_WE_n;
    logic          busy;

    modport slave (
        input  vga_req, vga_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  SRAM_D_i,
        output vga_ack, vga_rdata, cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output SRAM_A, SRAM_D_o, SRAM_D_oe, SRAM_WE_n, busy
    );

    modport master (
        output vga_req, vga_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output SRAM_D_i,
        input  vga_ack, vga_rdata, cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  SRAM_A, SRAM_D_o, SRAM_D_oe, SRAM_WE_n, busy
    );
endinterface
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_pick
//  Purpose  : Combinational grant selection. VGA has priority until it has
//             taken VGA_BURST consecutive grants while CPU/DMA waits; CPU and
//             DMA share the remaining slots round-robin.
//  Ports    : vga_req_i/cpu_req_i/dma_req_i  request levels
//             vga_run_i    consecutive VGA grant count (saturated)
//             rr_ptr_i     CPU/DMA master favoured on a tie
//             gnt_valid_o  some request is present
//             gnt_id_o     selected requester
//  Revision : 1.0  initial release
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int VGA_BURST = 4,
    parameter int RW        = 3
)(
    input  logic          vga_req_i,
    input  logic          cpu_req_i,
    input  logic          dma_req_i,
    input  logic [RW-1:0] vga_run_i,
    input  req_id_t       rr_ptr_i,
    output logic          gnt_valid_o,
    output req_id_t       gnt_id_o
);
    logic cd_pending;
    logic vga_blocked;

    always_comb begin
        cd_pending  = cpu_req_i | dma_req_i;
        vga_blocked = (vga_run_i == RW'(VGA_BURST)) && cd_pending;
        gnt_valid_o = vga_req_i | cd_pending;
        gnt_id_o    = REQ_VGA;
        if (vga_req_i && !vga_blocked) begin
            gnt_id_o = REQ_VGA;
        end else if (cpu_req_i && dma_req_i) begin
            gnt_id_o = rr_ptr_i;
        end else if (cpu_req_i) begin
            gnt_id_o = REQ_CPU;
        end else if (dma_req_i) begin
            gnt_id_o = REQ_DMA;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Shares one 8-bit external SRAM between VGA fetch (read-only),
//             CPU and SD/DMA. Sequences each access: address setup, WE_n
//             strobe, data drive, and a one-clock write turnaround.
//  Ports    : clk      SRAM clock
//             reset_n  asynchronous active-low reset
//             bus      sram_port_arbiter_if.slave (requesters + SRAM pads)
//  Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3,
    parameter int VGA_BURST     = 4,
    parameter int AW            = AW_DEFAULT
)(
    input  logic                  clk,
    input  logic                  reset_n,
    sram_port_arbiter_if.slave    bus
);
    localparam int CW = $clog2(ACCESS_CYCLES);
    localparam int RW = $clog2(VGA_BURST + 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    req_id_t       who_q;
    logic [RW-1:0] vga_run_q;
    req_id_t       rr_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic          oe_q;
    logic          we_n_q;
    logic          vga_ack_q, cpu_ack_q, dma_ack_q;
    logic [7:0]    vga_rdata_q, cpu_rdata_q, dma_rdata_q;

    logic          gnt_valid;
    req_id_t       gnt_id;
    logic [AW-1:0] sel_addr;
    logic [7:0]    sel_wdata;
    logic          sel_we;

    sram_arb_pick #(
        .VGA_BURST (VGA_BURST),
        .RW        (RW)
    ) u_pick (
        .vga_req_i   (bus.vga_req),
        .cpu_req_i   (bus.cpu_req),
        .dma_req_i   (bus.dma_req),
        .vga_run_i   (vga_run_q),
        .rr_ptr_i    (rr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // Address/data of the requester being granted this clock.
    always_comb begin
        sel_addr  = bus.vga_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
        case (gnt_id)
            REQ_CPU: begin
                sel_addr  = bus.cpu_addr;
                sel_wdata = bus.cpu_wdata;
                sel_we    = bus.cpu_we;
            end
            REQ_DMA: begin
                sel_addr  = bus.dma_addr;
                sel_wdata = bus.dma_wdata;
                sel_we    = bus.dma_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            who_q       <= REQ_VGA;
            vga_run_q   <= '0;
            rr_q        <= REQ_CPU;
            addr_q      <= '0;
            wdata_q     <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
            vga_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            vga_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= CW'(ACCESS_CYCLES - 1);
                        who_q   <= gnt_id;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        we_q    <= sel_we;
                        oe_q    <= sel_we;   // data driven for the whole write
                        if (gnt_id == REQ_VGA) begin
                            if (vga_run_q != RW'(VGA_BURST)) begin
                                vga_run_q <= vga_run_q + RW'(1);
                            end
                        end else begin
                            vga_run_q <= '0;
                            rr_q      <= (gnt_id == REQ_CPU) ? REQ_DMA : REQ_CPU;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        case (who_q)
                            REQ_VGA: vga_ack_q <= 1'b1;
                            REQ_CPU: cpu_ack_q <= 1'b1;
                            REQ_DMA: dma_ack_q <= 1'b1;
                            default: ;
                        endcase
                        if (we_q) begin
                            we_n_q  <= 1'b1;
                            state_q <= ST_TURN;
                        end else begin
                            state_q <= ST_IDLE;
                            case (who_q)
                                REQ_VGA: vga_rdata_q <= bus.SRAM_D_i;
                                REQ_CPU: cpu_rdata_q <= bus.SRAM_D_i;
                                REQ_DMA: dma_rdata_q <= bus.SRAM_D_i;
                                default: ;
                            endcase
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        // First access clock is address setup; strobe from then on.
                        if (we_q) begin
                            we_n_q <= 1'b0;
                        end
                    end
                end
                ST_TURN: begin
                    oe_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.vga_ack   = vga_ack_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.vga_rdata = vga_rdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.SRAM_A    = addr_q;
    assign bus.SRAM_D_o  = wdata_q;
    assign bus.SRAM_D_oe = oe_q;
    assign bus.SRAM_WE_n = we_n_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
